// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM encodings, byte type
// and the bit-period helper that the receive side will reuse.
package uart_tx_pkg;

  typedef logic [7:0] uart_byte_t;

  localparam int DATA_BITS = 8;

  // FSM state encodings, 2 bits
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Clock cycles per serial bit, truncated; callers keep the result >= 2
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// One-byte valid/ready handshake between the dump formatter and the UART.
interface uart_if;
  import uart_tx_pkg::*;

  uart_byte_t uart_data;
  logic       uart_valid;
  logic       uart_ready;

  modport master (output uart_data, output uart_valid, input uart_ready);
  modport slave  (input uart_data, input uart_valid, output uart_ready);

endinterface

// File: rtl/uart_byte_fifo.sv
// Byte-wide synchronous FIFO with first-word-fall-through read. Pointers
// carry one extra wrap bit so full and empty are told apart without a count.
module uart_byte_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  uart_byte_t din,
  output uart_byte_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  uart_byte_t    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is only taken when an entry leaves on the same edge
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Next pointer values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers; reset flushes the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO in front of an 8N1/8N2 framer. tx comes
// straight from a flop so the line never sees a combinational glitch.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | line high, waiting for the FIFO to hold a byte
//   S_START | start bit (tx=0) held one bit period
//   S_DATA  | eight data bits, LSB first, one bit period each
//   S_STOP  | tx=1 for STOP_BITS bit periods, then next byte or idle
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_HZ     = 32000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic clk,
  input  logic reset,
  uart_if.slave up,
  output logic tx,
  output logic busy,
  output logic overflow
);

  localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic             stop_q, stop_d;
  uart_byte_t       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             overflow_q, overflow_d;

  uart_byte_t fifo_dout;
  logic       fifo_full, fifo_empty;
  logic       push, pop;
  logic       bit_end;

  assign up.uart_ready = !fifo_full;
  assign push          = up.uart_valid && !fifo_full;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (up.uart_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_end  = (baud_q == CNT_LAST);
  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != S_IDLE) || !fifo_empty;

  // Sticky drop flag: a byte offered while the FIFO is full is lost
  always_comb begin
    overflow_d = overflow_q | (up.uart_valid & fifo_full);
  end

  // Framer FSM, baud counter and shift register next-state
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == BIT_LAST) begin
            tx_d    = 1'b1;
            stop_d  = 1'b0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) begin
            // Chain straight into the next start bit when a byte is waiting
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = fifo_dout;
              tx_d    = 1'b0;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State registers; reset abandons any frame and forces the line high
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 8 clocks per bit, with a second instance
// configured for two stop bits.
module tb_uart_tx;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;   // transmission order from bit 10 down: start, d0..d7, stop, stop
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic tx, busy, overflow;
  logic tx2, busy2, overflow2;

  int checks = 0;
  int errors = 0;

  uart_if u_if ();
  uart_if u_if2 ();

  uart_tx #(.CLK_HZ(8), .BAUD(1), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .up       (u_if),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  uart_tx #(.CLK_HZ(8), .BAUD(1), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .up       (u_if2),
    .tx       (tx2),
    .busy     (busy2),
    .overflow (overflow2)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b);
    logic [10:0] f;
    f[10] = 1'b0;
    for (int i = 0; i < 8; i++) f[9-i] = b[i];
    f[1] = 1'b1;
    f[0] = 1'b1;
    return f;
  endfunction

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  // Samples nbits bit periods of 8 cycles each, starting at the next negedge.
  task automatic check_frame(input logic [10:0] exp, input int nbits, input int which, input string nm);
    for (int i = 0; i < nbits; i++) begin
      int bad;
      logic e;
      bad = 0;
      e = exp[10-i];
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        if (((which == 0) ? tx : tx2) !== e) bad++;
      end
      chk($sformatf("%s bit%0d wrong-level samples", nm, i), bad, 0);
    end
  endtask

  // Returns just after the edge on which tx first goes low.
  task automatic wait_tx_low(input int which, input string nm);
    int n;
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      if (((which == 0) ? tx : tx2) === 1'b0) break;
      n++;
    end
    if (n >= 200) chk({nm, " start-bit timeout"}, 0, 1);
  endtask

  task automatic send_one(input logic [7:0] d, input logic [10:0] fr, input string nm);
    @(negedge clk);
    u_if.uart_data  = d;
    u_if.uart_valid = 1'b1;
    @(posedge clk); #1;
    u_if.uart_valid = 1'b0;
    chk({nm, " tx still idle on push edge"}, tx, 1);
    chk({nm, " busy after push"}, busy, 1);
    @(posedge clk); #1;
    chk({nm, " tx low one edge after push"}, tx, 0);
    check_frame(fr, 10, 0, nm);
    chk({nm, " busy in last stop cycle"}, busy, 1);
    @(negedge clk);
    chk({nm, " busy after frame"}, busy, 0);
    chk({nm, " tx idle after frame"}, tx, 1);
  endtask

  vec_t       vecs [7];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  initial begin
    vecs[0] = '{8'h41, 11'b0_10000010_11};
    vecs[1] = '{8'h00, 11'b0_00000000_11};
    vecs[2] = '{8'hFF, 11'b0_11111111_11};
    vecs[3] = '{8'hA5, 11'b0_10100101_11};
    vecs[4] = '{8'h80, 11'b0_00000001_11};
    vecs[5] = '{8'h01, 11'b0_10000000_11};
    vecs[6] = '{8'h3C, 11'b0_00111100_11};

    reset            = 1'b1;
    u_if.uart_valid  = 1'b0;
    u_if.uart_data   = 8'h00;
    u_if2.uart_valid = 1'b0;
    u_if2.uart_data  = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset tx", tx, 1);
    chk("reset ready", u_if.uart_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset overflow", overflow, 0);
    chk("reset tx (2 stop)", tx2, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single bytes from the table
    foreach (vecs[i])
      send_one(vecs[i].data, vecs[i].frame, $sformatf("byte %02h", vecs[i].data));

    // Burst of five, then a byte offered while full. The first byte leaves the
    // FIFO on the following edge, so the FIFO only fills at the fifth write.
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk($sformatf("burst ready before write %0d", i + 1), u_if.uart_ready, 1);
          u_if.uart_data  = 8'h30 + 8'(i);
          u_if.uart_valid = 1'b1;
        end
        @(negedge clk);
        u_if.uart_valid = 1'b0;
        chk("burst ready after fill", u_if.uart_ready, 0);
        chk("burst overflow before drop", overflow, 0);
        u_if.uart_data  = 8'h7E;
        u_if.uart_valid = 1'b1;
        @(negedge clk);
        u_if.uart_valid = 1'b0;
        chk("overflow set on drop", overflow, 1);
      end
      begin
        wait_tx_low(0, "burst");
        for (int i = 0; i < 5; i++)
          check_frame(mk_frame(8'h30 + 8'(i)), 10, 0, $sformatf("burst frame %0d", i));
        @(negedge clk);
        chk("burst busy after last frame", busy, 0);
        chk("overflow still set", overflow, 1);
      end
    join
    begin
      int lows;
      lows = 0;
      repeat (100) begin
        @(negedge clk);
        if (tx !== 1'b1) lows++;
      end
      chk("dropped byte never sent (tx low samples)", lows, 0);
    end

    // Two stop bits: 16-cycle stop then the next start bit immediately
    fork
      begin
        @(negedge clk);
        u_if2.uart_data  = 8'h55;
        u_if2.uart_valid = 1'b1;
        @(negedge clk);
        u_if2.uart_data  = 8'hC3;
        @(negedge clk);
        u_if2.uart_valid = 1'b0;
      end
      begin
        wait_tx_low(1, "stop2");
        check_frame(mk_frame(8'h55), 11, 1, "stop2 frame 0");
        check_frame(mk_frame(8'hC3), 11, 1, "stop2 frame 1");
        @(negedge clk);
        chk("stop2 tx idle after", tx2, 1);
        chk("stop2 busy after", busy2, 0);
      end
    join

    // Reset in the middle of a data bit while tx is low, with a byte queued
    @(negedge clk);
    u_if.uart_data  = 8'h00;
    u_if.uart_valid = 1'b1;
    @(negedge clk);
    u_if.uart_data  = 8'h12;
    @(negedge clk);
    u_if.uart_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid-frame tx low before reset", tx, 0);
    chk("mid-frame busy before reset", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid-frame reset tx", tx, 1);
    chk("mid-frame reset ready", u_if.uart_ready, 1);
    chk("mid-frame reset busy", busy, 0);
    chk("mid-frame reset overflow", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int lows, busys;
      lows = 0;
      busys = 0;
      repeat (120) begin
        @(negedge clk);
        if (tx !== 1'b1) lows++;
        if (busy !== 1'b0) busys++;
      end
      chk("after reset no frame (tx low samples)", lows, 0);
      chk("after reset busy samples", busys, 0);
    end

    // Dump-formatter stream: CR, 4 hex address digits, ':', then " HH" per byte
    begin
      logic [7:0]  mem [8];
      logic [15:0] addr;
      int          ferr;
      mem = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h9A, 8'h5C};
      for (int ln = 0; ln < 2; ln++) begin
        addr = 16'h0100 + 16'(4 * ln);
        exp_q.push_back(8'h0D);
        for (int k = 3; k >= 0; k--) exp_q.push_back(hexc(addr[4*k +: 4]));
        exp_q.push_back(8'h3A);
        for (int k = 0; k < 4; k++) begin
          exp_q.push_back(8'h20);
          exp_q.push_back(hexc(mem[4*ln+k][7:4]));
          exp_q.push_back(hexc(mem[4*ln+k][3:0]));
        end
      end
      ferr = 0;
      fork
        begin
          foreach (exp_q[i]) begin
            int w;
            w = 0;
            @(negedge clk);
            while (!u_if.uart_ready && w < 300) begin
              @(negedge clk);
              w++;
            end
            if (w >= 300) begin
              chk("formatter ready timeout", 0, 1);
              break;
            end
            u_if.uart_data  = exp_q[i];
            u_if.uart_valid = 1'b1;
            @(negedge clk);
            u_if.uart_valid = 1'b0;
          end
        end
        begin
          int cyc;
          logic [7:0] b;
          cyc = 0;
          while (got_q.size() < exp_q.size() && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (tx === 1'b0) begin
              repeat (4) @(negedge clk);
              if (tx !== 1'b0) ferr++;
              for (int i = 0; i < 8; i++) begin
                repeat (8) @(negedge clk);
                b[i] = tx;
              end
              repeat (8) @(negedge clk);
              if (tx !== 1'b1) ferr++;
              got_q.push_back(b);
              cyc += 76;
            end
          end
        end
      join
      chk("stream byte count", got_q.size(), exp_q.size());
      foreach (exp_q[i])
        if (i < got_q.size()) chk($sformatf("stream char %0d", i), got_q[i], exp_q[i]);
      chk("stream framing errors", ferr, 0);
      chk("stream overflow", overflow, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
